bcd_display_sequencer: RTL and testbench

Sequential front end for the six-digit seven-segment display on the mini ALU.
- Accepts a 20-bit ALU result through a valid/ready handshake.
- Converts it to six BCD digits with an iterative shift-add-3 (double dabble), one bit per clock.
- Drives registered, atomically updated segment patterns.
- Replaces the combinational divide/modulo conversion path, removing its long critical path.

---
 rtl/bcd_display_pkg.sv | 36 +++
 rtl/bcd_add3_digit.sv | 17 +
 rtl/bcd_display_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD display sequencer: default sizes, FSM
// state type, blank pattern and the active-low seven-segment encoder.
package bcd_display_pkg;

    localparam int DEF_WIDTH  = 20;
    localparam int DEF_DIGITS = 6;
    localparam int CNT_W      = 5;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp is kept off.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction.
    always_comb begin
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_display_sequencer.sv
// Sequential binary-to-BCD front end for the six-digit seven-segment display.
// Accepts a result over valid/ready, runs one double-dabble step per clock and
// updates bcd_digits/seg_out/ovf atomically with a one-cycle done pulse.
// Optional build macro LEADING_ZERO_BLANK_EN blanks segment bytes above the
// most significant nonzero digit (digit 0 is always shown).
module bcd_display_sequencer
    import bcd_display_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_result,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic [8*DIGITS-1:0]   seg_out,
    output logic                  done,
    output logic                  ovf
);

    localparam int ACC_W = 4 * (DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [8*DIGITS-1:0] SEG_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
`else
    localparam logic [8*DIGITS-1:0] SEG_RESET = {DIGITS{SEG_ZERO}};
`endif

    state_e                 state_r;
    state_e                 state_next_s;
    logic [WIDTH-1:0]       shreg_r;
    logic [ACC_W-1:0]       acc_r;
    logic [CNT_W-1:0]       cnt_r;

    logic                   load_s;
    logic                   step_s;
    logic                   final_s;
    logic                   ready_next_s;

    logic [ACC_W-1:0]       acc_add_s;
    logic [ACC_W-1:0]       acc_shift_s;
    logic [WIDTH-1:0]       sh_shift_s;
    logic [8*DIGITS-1:0]    seg_next_s;
    logic                   ovf_next_s;

    logic                   in_ready_r;
    logic [4*DIGITS-1:0]    bcd_digits_r;
    logic [8*DIGITS-1:0]    seg_out_r;
    logic                   done_r;
    logic                   ovf_r;

    // One correction cell per accumulator digit, including the overflow digit.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .din  (acc_r[4*g +: 4]),
            .dout (acc_add_s[4*g +: 4])
        );
    end

    // Corrected accumulator shifted left by one, taking in the next input bit.
    always_comb begin
        acc_shift_s = {acc_add_s[ACC_W-2:0], shreg_r[WIDTH-1]};
        sh_shift_s  = {shreg_r[WIDTH-2:0], 1'b0};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_next_s = CONVERT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_r == LAST_STEP) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = CONVERT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control decodes; ready is registered from the upcoming state.
    always_comb begin
        load_s       = 1'b0;
        step_s       = 1'b0;
        final_s      = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = in_valid && in_ready_r;
            end
            CONVERT: begin
                step_s  = 1'b1;
                final_s = (cnt_r == LAST_STEP);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        ready_next_s = (state_next_s == IDLE);
    end

    // Double-dabble datapath: load on accept, one shift-add-3 step per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_r <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
        end else if (load_s) begin
            shreg_r <= in_result;
            acc_r   <= '0;
            cnt_r   <= '0;
        end else if (step_s) begin
            shreg_r <= sh_shift_s;
            acc_r   <= acc_shift_s;
            cnt_r   <= cnt_r + 5'd1;
        end
    end

    // Segment bytes for the final accumulator value, optionally blanking leading zeros.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        seg_next_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_next_s[8*i +: 8] = seg_encode(acc_shift_s[4*i +: 4]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (acc_shift_s[4*i +: 4] == 4'd0);
            if (zero_run) begin
                seg_next_s[8*i +: 8] = SEG_BLANK;
            end else begin
                seg_next_s[8*i +: 8] = seg_encode(acc_shift_s[4*i +: 4]);
            end
        end
`else
        zero_run = 1'b0;
`endif
    end

    // Overflow: a nonzero seventh digit, or a carry lost off the top of the accumulator.
    always_comb begin
        ovf_next_s = (acc_shift_s[ACC_W-1 -: 4] != 4'd0) || acc_add_s[ACC_W-1];
    end

    // Output registers update only on the final step, so no partial result is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            done_r       <= 1'b0;
            bcd_digits_r <= '0;
            seg_out_r    <= SEG_RESET;
            ovf_r        <= 1'b0;
        end else begin
            in_ready_r <= ready_next_s;
            done_r     <= final_s;
            if (final_s) begin
                bcd_digits_r <= acc_shift_s[4*DIGITS-1:0];
                seg_out_r    <= seg_next_s;
                ovf_r        <= ovf_next_s;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign done       = done_r;
    assign bcd_digits = bcd_digits_r;
    assign seg_out    = seg_out_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed self-checking bench for bcd_display_sequencer. Expected values are
// hand-computed constants; LEADING_ZERO_BLANK_EN selects the blanked patterns.
module tb_bcd_display_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_result;
    logic [23:0] bcd_digits;
    logic [47:0] seg_out;
    logic        done;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    bcd_display_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .bcd_digits (bcd_digits),
        .seg_out    (seg_out),
        .done       (done),
        .ovf        (ovf)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] pick(input logic [47:0] full, input logic [47:0] blanked);
`ifdef LEADING_ZERO_BLANK_EN
        return blanked;
`else
        return full;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done, checking in_ready stays low while busy.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            check("busy_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic convert(input logic [19:0] v, input logic [23:0] eb,
                           input logic [47:0] es, input logic eo, input string tag);
        int n;
        check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_result = v;
        @(negedge clk);
        in_valid  = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'd20);
        check({tag, "_bcd"}, {40'd0, bcd_digits}, {40'd0, eb});
        check({tag, "_seg"}, {16'd0, seg_out}, {16'd0, es});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int n;
        int done_cnt;
        logic [47:0] seg_rst;
        seg_rst   = pick(48'hC0C0C0C0C0C0, 48'hFFFFFFFFFFC0);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = 20'd0;
        repeat (3) @(negedge clk);

        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_bcd", {40'd0, bcd_digits}, 64'd0);
        check("rst_seg", {16'd0, seg_out}, {16'd0, seg_rst});
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {63'd0, in_ready}, 64'd1);

        convert(20'd123456, 24'h123456, 48'hF9A4B0999282, 1'b0, "v123456");
        convert(20'd0, 24'h000000, pick(48'hC0C0C0C0C0C0, 48'hFFFFFFFFFFC0), 1'b0, "v0");
        convert(20'd999999, 24'h999999, 48'h909090909090, 1'b0, "v999999");
        convert(20'd1048575, 24'h048575, pick(48'hC0998092F892, 48'hFF998092F892), 1'b1, "vmax");
        convert(20'd7, 24'h000007, pick(48'hC0C0C0C0C0F8, 48'hFFFFFFFFFFF8), 1'b0, "v7");

        // in_valid held: 11 accepted now, 22 waits until the block is idle again.
        in_valid  = 1'b1;
        in_result = 20'd11;
        @(negedge clk);
        in_result = 20'd22;
        wait_done(n);
        check("hold_lat1", 64'(n), 64'd20);
        check("hold_bcd1", {40'd0, bcd_digits}, 64'h000011);
        check("hold_seg1", {16'd0, seg_out}, {16'd0, pick(48'hC0C0C0C0F9F9, 48'hFFFFFFFFF9F9)});
        @(negedge clk);
        n = 1;
        in_valid = 1'b0;
        check("hold_done_pulse", {63'd0, done}, 64'd0);
        check("hold_accept2", {63'd0, in_ready}, 64'd0);
        check("hold_no_partial", {40'd0, bcd_digits}, 64'h000011);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("hold_gap", 64'(n), 64'd21);
        check("hold_bcd2", {40'd0, bcd_digits}, 64'h000022);
        check("hold_seg2", {16'd0, seg_out}, {16'd0, pick(48'hC0C0C0C0A4A4, 48'hFFFFFFFFA4A4)});
        @(negedge clk);

        // Reset in the middle of converting 555555.
        in_valid  = 1'b1;
        in_result = 20'd555555;
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_bcd", {40'd0, bcd_digits}, 64'd0);
        check("abort_seg", {16'd0, seg_out}, {16'd0, seg_rst});
        check("abort_ovf", {63'd0, ovf}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_ready_low", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        convert(20'd7, 24'h000007, pick(48'hC0C0C0C0C0F8, 48'hFFFFFFFFFFF8), 1'b0, "recover7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
